// File: rtl/hubris.sv
// rtl/hubris.sv - single-cycle RV32I core with internal instruction/data memory

// Byte-addressed memory with two combinational read ports and one byte-strobed write port.
// Every port moves MEMORY_WIDTH_IN_BYTE consecutive bytes starting at an arbitrary offset.
// Bytes beyond the end of the array read as zero and are never written.
module byte_memory #(
    parameter int MEMORY_WIDTH_IN_BYTE = 4,
    parameter int MEMORY_DEPTH_IN_WORD = 16384
) (
    input  logic                              clk,
    input  logic [31:0]                       read_a_offset,
    output logic [8*MEMORY_WIDTH_IN_BYTE-1:0] read_a_data,
    input  logic [31:0]                       read_b_offset,
    output logic [8*MEMORY_WIDTH_IN_BYTE-1:0] read_b_data,
    input  logic                              write_enable,
    input  logic [31:0]                       write_offset,
    input  logic [8*MEMORY_WIDTH_IN_BYTE-1:0] write_data,
    input  logic [MEMORY_WIDTH_IN_BYTE-1:0]   write_strobe
);
    localparam int SIZE = MEMORY_WIDTH_IN_BYTE * MEMORY_DEPTH_IN_WORD;
    localparam int AW   = $clog2(SIZE);

    logic [7:0]  mem [0:SIZE-1];
    logic [31:0] w_idx [MEMORY_WIDTH_IN_BYTE];

    for (genvar g = 0; g < MEMORY_WIDTH_IN_BYTE; g++) begin : g_byte
        logic [31:0] a_idx;
        logic [31:0] b_idx;
        assign a_idx    = read_a_offset + 32'(g);
        assign b_idx    = read_b_offset + 32'(g);
        assign w_idx[g] = write_offset + 32'(g);
        assign read_a_data[8*g +: 8] = (a_idx < 32'(SIZE)) ? mem[a_idx[AW-1:0]] : 8'h00;
        assign read_b_data[8*g +: 8] = (b_idx < 32'(SIZE)) ? mem[b_idx[AW-1:0]] : 8'h00;
    end

    // Store the strobed bytes; no reset so preloaded contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MEMORY_WIDTH_IN_BYTE; i++) begin
            if (write_enable && write_strobe[i] && (w_idx[i] < 32'(SIZE))) begin
                mem[w_idx[i][AW-1:0]] <= write_data[8*i +: 8];
            end
        end
    end
endmodule

// Maps the flat address space onto the instruction region (at 0) and the data region.
module unified_memory #(
    parameter int          INST_SIZE_IN_BYTE = 65536,
    parameter logic [31:0] DATA_START_ADDR   = 32'h0001_0000,
    parameter int          DATA_SIZE_IN_BYTE = 65536
) (
    input  logic        clk,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    input  logic [31:0] load_addr,
    output logic [31:0] load_data,
    input  logic        store_enable,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  store_strobe
);
    logic [31:0] inst_fetch_word;
    logic [31:0] inst_load_word;
    logic [31:0] data_load_word;
    logic [31:0] data_port_b_unused;
    logic [31:0] load_data_offset;
    logic [31:0] store_data_offset;
    logic        load_in_data;
    logic        load_in_inst;
    logic        store_in_data;
    logic        fetch_in_inst;

    assign load_data_offset  = load_addr - DATA_START_ADDR;
    assign store_data_offset = store_addr - DATA_START_ADDR;
    assign load_in_data  = (load_addr >= DATA_START_ADDR) && (load_data_offset < 32'(DATA_SIZE_IN_BYTE));
    assign store_in_data = (store_addr >= DATA_START_ADDR) && (store_data_offset < 32'(DATA_SIZE_IN_BYTE));
    assign load_in_inst  = load_addr < 32'(INST_SIZE_IN_BYTE);
    assign fetch_in_inst = fetch_addr < 32'(INST_SIZE_IN_BYTE);

    byte_memory #(
        .MEMORY_WIDTH_IN_BYTE(4),
        .MEMORY_DEPTH_IN_WORD(INST_SIZE_IN_BYTE / 4)
    ) inst_memory_instance (
        .clk           (clk),
        .read_a_offset ({fetch_addr[31:2], 2'b00}),
        .read_a_data   (inst_fetch_word),
        .read_b_offset (load_addr),
        .read_b_data   (inst_load_word),
        .write_enable  (1'b0),
        .write_offset  (32'h0),
        .write_data    (32'h0),
        .write_strobe  (4'h0)
    );

    byte_memory #(
        .MEMORY_WIDTH_IN_BYTE(4),
        .MEMORY_DEPTH_IN_WORD(DATA_SIZE_IN_BYTE / 4)
    ) data_memory_instance (
        .clk           (clk),
        .read_a_offset (load_data_offset),
        .read_a_data   (data_load_word),
        .read_b_offset (32'h0),
        .read_b_data   (data_port_b_unused),
        .write_enable  (store_enable && store_in_data),
        .write_offset  (store_data_offset),
        .write_data    (store_data),
        .write_strobe  (store_strobe)
    );

    assign fetch_data = fetch_in_inst ? inst_fetch_word : 32'h0;
    assign load_data  = load_in_data ? data_load_word :
                        load_in_inst ? inst_load_word : 32'h0;
endmodule

// Integer register file: combinational reads, x0 reads as zero and ignores writes.
module register_file #(
    parameter int REG_NUMBER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        rd_we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    logic [31:0] regfile [0:REG_NUMBER-1];

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regfile[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regfile[rs2_addr];

    // Clear every register on reset; commit the rd write otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUMBER; i++) begin
                regfile[i] <= 32'h0;
            end
        end else if (rd_we && (rd_addr != 5'd0)) begin
            regfile[rd_addr] <= rd_data;
        end
    end
endmodule

// Single-cycle core: fetch, decode, execute and commit in one clock.
module hubris #(
    parameter int          REG_NUMBER        = 32,
    parameter logic [31:0] INST_START_ADDR   = 32'h0000_0000,
    parameter int          INST_SIZE_IN_BYTE = 65536,
    parameter logic [31:0] DATA_START_ADDR   = 32'h0001_0000,
    parameter int          DATA_SIZE_IN_BYTE = 65536
) (
    input  logic clk,
    input  logic reset,
    output logic halt
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt_reg;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] load_addr, store_addr, load_raw;

    logic [31:0] next_pc;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        store_en;
    logic [3:0]  store_strobe;
    logic        illegal;
    logic        is_system;
    logic        halt_now;
    logic        commit;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign load_addr  = rs1_data + imm_i;
    assign store_addr = rs1_data + imm_s;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    register_file #(
        .REG_NUMBER(REG_NUMBER)
    ) register_file_instance (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_we    (rd_we && commit),
        .rd_addr  (rd),
        .rd_data  (rd_wdata)
    );

    unified_memory #(
        .INST_SIZE_IN_BYTE (INST_SIZE_IN_BYTE),
        .DATA_START_ADDR   (DATA_START_ADDR),
        .DATA_SIZE_IN_BYTE (DATA_SIZE_IN_BYTE)
    ) unified_memory_instance (
        .clk          (clk),
        .fetch_addr   (pc),
        .fetch_data   (instr),
        .load_addr    (load_addr),
        .load_data    (load_raw),
        .store_enable (store_en && commit),
        .store_addr   (store_addr),
        .store_data   (rs2_data),
        .store_strobe (store_strobe)
    );

    // Decode and execute the instruction at pc; undefined encodings flag illegal.
    always_comb begin
        next_pc      = pc + 32'd4;
        rd_we        = 1'b0;
        rd_wdata     = 32'h0;
        store_en     = 1'b0;
        store_strobe = 4'h0;
        illegal      = 1'b0;
        is_system    = 1'b0;
        case (opcode)
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc + 32'd4;
                next_pc  = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc + 32'd4;
                    next_pc  = (rs1_data + imm_i) & ~32'd1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  if (rs1_data == rs2_data) next_pc = pc + imm_b;
                    3'b001:  if (rs1_data != rs2_data) next_pc = pc + imm_b;
                    3'b100:  if ($signed(rs1_data) <  $signed(rs2_data)) next_pc = pc + imm_b;
                    3'b101:  if ($signed(rs1_data) >= $signed(rs2_data)) next_pc = pc + imm_b;
                    3'b110:  if (rs1_data <  rs2_data) next_pc = pc + imm_b;
                    3'b111:  if (rs1_data >= rs2_data) next_pc = pc + imm_b;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_wdata = {{24{load_raw[7]}}, load_raw[7:0]};
                    3'b001:  rd_wdata = {{16{load_raw[15]}}, load_raw[15:0]};
                    3'b010:  rd_wdata = load_raw;
                    3'b100:  rd_wdata = {24'h0, load_raw[7:0]};
                    3'b101:  rd_wdata = {16'h0, load_raw[15:0]};
                    default: begin
                        rd_we   = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_STORE: begin
                store_en = 1'b1;
                case (funct3)
                    3'b000:  store_strobe = 4'b0001;
                    3'b001:  store_strobe = 4'b0011;
                    3'b010:  store_strobe = 4'b1111;
                    default: begin
                        store_en = 1'b0;
                        illegal  = 1'b1;
                    end
                endcase
            end
            OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                    illegal = 1'b1;
                end else begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_data, imm_i);
                end
            end
            OP_REG: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    rd_we    = 1'b1;
                    rd_wdata = alu(funct3, instr[30], rs1_data, rs2_data);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_FENCE: begin
            end
            OP_SYSTEM: begin
                is_system = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign halt_now = illegal || is_system;
    assign commit   = !halt_now && !halt_reg;
    assign halt     = reset && (halt_reg || halt_now);

    // Advance the pc only while running; a halting instruction leaves it in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= INST_START_ADDR;
        end else if (commit) begin
            pc <= next_pc;
        end
    end

    // Remember a halt so the core stays frozen until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_reg <= 1'b0;
        end else if (halt_now) begin
            halt_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hubris.sv
// tb/tb_hubris.sv - directed program tests for the hubris core with a result scoreboard
module tb_hubris;
    localparam int K_REG   = 0;
    localparam int K_PC    = 1;
    localparam int K_HALT  = 2;
    localparam int K_DMEM  = 3;
    localparam int K_IWORD = 4;
    localparam int K_CYC   = 5;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    logic halt;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          checks;
    int          failures;
    int          run_cycles;

    hubris dut (
        .clk   (clk),
        .reset (reset),
        .halt  (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            K_REG:   return dut.register_file_instance.regfile[idx];
            K_PC:    return dut.pc;
            K_HALT:  return {31'b0, halt};
            K_DMEM:  return {24'h0, dut.unified_memory_instance.data_memory_instance.mem[idx]};
            K_IWORD: return {dut.unified_memory_instance.inst_memory_instance.mem[idx+3],
                             dut.unified_memory_instance.inst_memory_instance.mem[idx+2],
                             dut.unified_memory_instance.inst_memory_instance.mem[idx+1],
                             dut.unified_memory_instance.inst_memory_instance.mem[idx]};
            default: return 32'(run_cycles);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.idx = idx;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Hold reset for four cycles with the current program loaded, checking the reset state.
    task automatic start_test();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            dut.unified_memory_instance.inst_memory_instance.mem[i] = 8'h00;
        end
        for (int w = 0; w < prog.size(); w++) begin
            for (int b = 0; b < 4; b++) begin
                dut.unified_memory_instance.inst_memory_instance.mem[4*w+b] = prog[w][8*b +: 8];
            end
        end
        repeat (4) @(negedge clk);
        expect_val("reset_pc", K_PC, 0, 32'h0);
        expect_val("reset_halt", K_HALT, 0, 32'h0);
        expect_val("reset_x1", K_REG, 1, 32'h0);
        drain();
    endtask

    // Release reset and count rising edges until halt; then idle a few edges to prove the freeze.
    task automatic run_program(input int max_cycles);
        run_cycles = 0;
        reset = 1'b1;
        #1;
        while (!halt && run_cycles < max_cycles) begin
            @(posedge clk);
            @(negedge clk);
            run_cycles++;
        end
        if (!halt) run_cycles = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        run_cycles = 0;
        reset = 1'b0;

        // Reset and first instruction
        prog = {enc_i(5, 0, 0, 1, 7'h13), 32'h0000_0073};
        start_test();
        expect_val("t1_cycles", K_CYC, 0, 32'd1);
        expect_val("t1_halt", K_HALT, 0, 32'd1);
        expect_val("t1_x1", K_REG, 1, 32'd5);
        expect_val("t1_pc_frozen", K_PC, 0, 32'd4);
        run_program(50);

        // ALU ops and x0
        prog = {enc_u(20'h80000, 2, 7'h37), enc_i(12'h404, 2, 5, 3, 7'h13),
                enc_i(4, 2, 5, 4, 7'h13), enc_i(7, 0, 0, 0, 7'h13),
                enc_r(0, 0, 2, 2, 5), enc_r(0, 0, 2, 3, 6), 32'h0000_0073};
        start_test();
        expect_val("t2_cycles", K_CYC, 0, 32'd6);
        expect_val("t2_x2", K_REG, 2, 32'h8000_0000);
        expect_val("t2_srai", K_REG, 3, 32'hF800_0000);
        expect_val("t2_srli", K_REG, 4, 32'h0800_0000);
        expect_val("t2_x0", K_REG, 0, 32'h0);
        expect_val("t2_slt", K_REG, 5, 32'h1);
        expect_val("t2_sltu", K_REG, 6, 32'h0);
        expect_val("t2_pc", K_PC, 0, 32'd24);
        run_program(50);

        // Loads and stores
        prog = {enc_u(20'h00010, 1, 7'h37), enc_i(-1, 0, 0, 2, 7'h13),
                enc_s(0, 2, 1, 2), enc_s(1, 0, 1, 0),
                enc_i(0, 1, 2, 3, 7'h03), enc_i(0, 1, 4, 4, 7'h03),
                enc_i(2, 1, 1, 5, 7'h03), 32'h0010_0073};
        start_test();
        for (int i = 0; i < 4; i++) dut.unified_memory_instance.data_memory_instance.mem[i] = 8'hAA;
        expect_val("t3_cycles", K_CYC, 0, 32'd7);
        expect_val("t3_lw", K_REG, 3, 32'hFFFF_00FF);
        expect_val("t3_lbu", K_REG, 4, 32'h0000_00FF);
        expect_val("t3_lh", K_REG, 5, 32'hFFFF_FFFF);
        expect_val("t3_dmem0", K_DMEM, 0, 32'hFF);
        expect_val("t3_dmem1", K_DMEM, 1, 32'h00);
        expect_val("t3_dmem2", K_DMEM, 2, 32'hFF);
        expect_val("t3_dmem3", K_DMEM, 3, 32'hFF);
        run_program(50);

        // Counting loop and jal: one addi, ten two-instruction passes, one jal
        prog = {enc_i(10, 0, 0, 1, 7'h13), enc_i(-1, 1, 0, 1, 7'h13),
                enc_b(-4, 0, 1, 1), enc_j(8, 2), enc_i(1, 0, 0, 3, 7'h13), 32'h0000_0073};
        start_test();
        expect_val("t4_cycles", K_CYC, 0, 32'(1 + 2 * 10 + 1));
        expect_val("t4_x1", K_REG, 1, 32'd0);
        expect_val("t4_x2", K_REG, 2, 32'd16);
        expect_val("t4_x3", K_REG, 3, 32'd0);
        expect_val("t4_pc", K_PC, 0, 32'd20);
        run_program(200);

        // auipc and jalr with an odd target
        prog = {enc_u(0, 1, 7'h17), enc_i(13, 1, 0, 2, 7'h67),
                enc_i(1, 0, 0, 3, 7'h13), enc_i(7, 0, 0, 4, 7'h13), 32'h0000_0073};
        start_test();
        expect_val("t5_cycles", K_CYC, 0, 32'd3);
        expect_val("t5_x1", K_REG, 1, 32'd0);
        expect_val("t5_x2", K_REG, 2, 32'd8);
        expect_val("t5_skipped", K_REG, 3, 32'd0);
        expect_val("t5_target", K_REG, 4, 32'd7);
        expect_val("t5_pc", K_PC, 0, 32'd16);
        run_program(50);

        // Runaway into zeroed memory, stores aimed at instruction memory
        prog = {enc_i(12'h055, 0, 0, 2, 7'h13), enc_s(0, 2, 0, 0),
                enc_s(4, 2, 0, 2), enc_i(0, 0, 2, 3, 7'h03)};
        start_test();
        expect_val("t6_cycles", K_CYC, 0, 32'd4);
        expect_val("t6_pc", K_PC, 0, 32'd16);
        expect_val("t6_halt", K_HALT, 0, 32'd1);
        expect_val("t6_lw_inst", K_REG, 3, prog[0]);
        expect_val("t6_imem0", K_IWORD, 0, prog[0]);
        expect_val("t6_imem1", K_IWORD, 4, prog[1]);
        run_program(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
